div_controller: RTL and testbench
=================================

DIV_CONTROLLER -- requirements
Module: div_controller

Interface
REQ-001 SHALL have parameter ITER, default 6, meaning number of quotient bits (shift/calc iterations).
REQ-002 SHALL have parameter CNT_W, default 3, meaning iteration counter width; 2^CNT_W > ITER.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-006 SHALL have port inBus, input, 6 bits: operand bus, observed for divide-by-zero check only.
REQ-007 SHALL have port ready, output, 1 bit: high in IDLE.
REQ-008 SHALL have port bus_take, output, 1 bit: operand word on inBus consumed this cycle.
REQ-009 SHALL have port out_valid, output, 1 bit: datapath outBus carries a result word this cycle.
REQ-010 SHALL have port err, output, 1 bit: divide-by-zero abort pulse.
REQ-011 SHALL have outputs select_A, output_sel, ldA, ldQ, shf, Q_sel, ldQ0, ld_Div, each 1 bit, driving the same-named datapath controls.

Function
REQ-012 SHALL be a Moore FSM; all outputs decoded from state only, no registered output lag.
REQ-013 SHALL use states IDLE, LD_DIV, LD_A, LD_Q, SHIFT, CALC, MERGE, OUT_Q, OUT_R, ERR.
REQ-014 IDLE: ready=1, all other outputs 0; start=1 at an edge -> LD_DIV; otherwise stay.
REQ-015 LD_DIV: ld_Div=1, bus_take=1 -> LD_A; inBus holds divisor.
REQ-016 LD_A: ldA=1, select_A=0, bus_take=1 -> LD_Q; inBus holds dividend high word.
REQ-017 LD_Q: ldQ=1, bus_take=1, counter cleared to 0 -> SHIFT; inBus holds dividend low word.
REQ-018 SHIFT: shf=1; Q_sel=0 when counter==0, else Q_sel=1 (insert previous quotient bit) -> CALC.
REQ-019 CALC: ldA=1, select_A=1, ldQ0=1; counter increments; -> SHIFT if new count < ITER, else -> MERGE.
REQ-020 MERGE: shf=1, Q_sel=1 (insert final quotient bit) -> OUT_Q.
REQ-021 OUT_Q: output_sel=1, out_valid=1 (quotient) -> OUT_R.
REQ-022 OUT_R: output_sel=0, out_valid=1 (remainder) -> IDLE.
REQ-023 Latency with ITER=6: start sampled at edge 0; bus_take cycles 1-3; SHIFT/CALC cycles 4-15; MERGE 16; out_valid cycles 17-18; ready at cycle 19.
REQ-024 start while not IDLE SHALL be ignored and SHALL NOT be queued.
REQ-025 At most one of ldA, ldQ, ld_Div SHALL be high in any cycle; shf and ldA SHALL never be high together.
REQ-026 Counter SHALL hold its value outside LD_Q and CALC and SHALL never exceed ITER.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE and counter 0, regardless of state or start; rst has priority over start.
REQ-028 After reset: ready=1, all other outputs 0.
REQ-029 Reset mid-operation SHALL abandon the division with no out_valid and no err.

Configuration
REQ-030 Macro DIV_CONTROLLER_DIV0_CHECK_EN SHALL enable divide-by-zero detection.
REQ-031 Defined: in LD_DIV, inBus==0 SHALL transition to ERR instead of LD_A; ERR: err=1 for one cycle, ld_Div already done, -> IDLE; no iterations, no out_valid.
REQ-032 Not defined: err tied 0, ERR unreachable, inBus unused; zero divisor runs the full sequence.

Verification
REQ-033 Reset then idle: rst=1 one cycle, start=0 -> ready=1, all other outputs 0 for 5 cycles.
REQ-034 Nominal run: start pulse, inBus=5,0,27 on bus_take cycles -> ld_Div/ldA/ldQ in cycles 1/2/3, 6 SHIFT/CALC pairs with Q_sel=0 only on first SHIFT, MERGE cycle 16, out_valid cycles 17-18 with output_sel 1 then 0, ready cycle 19.
REQ-035 Start ignored: start held high for 30 cycles -> exactly one division per 19-cycle window, next LD_DIV at cycle 20.
REQ-036 Reset mid-op: rst=1 at cycle 9 (during iterations) -> IDLE at cycle 10, no out_valid, counter 0, new start then runs full 18-cycle sequence.
REQ-037 Div0 with macro: inBus=0 in LD_DIV -> err=1 in cycle 2, ready=1 cycle 3, no ldA/shf ever; without macro same stimulus -> err never asserted, full sequence, out_valid cycles 17-18.
REQ-038 Exclusivity check: random start/rst over 10000 cycles -> REQ-025 and REQ-026 never violated.

Source files
------------

// File: rtl/div_controller.sv
// Control FSM for a restoring-style shift/subtract divider datapath.
// Latency: start seen at edge 0 -> 3 load cycles, 2*ITER iteration cycles, merge, 2 output cycles, ready again at cycle 2*ITER+7.
// Backpressure: none; start is only sampled in IDLE, so requests made while busy are dropped, not queued.
// Optional feature: define DIV_CONTROLLER_DIV0_CHECK_EN to abort on a zero divisor (err pulse, back to IDLE).
module div_controller #(
  parameter int ITER  = 6,
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] inBus,
  output logic       ready,
  output logic       bus_take,
  output logic       out_valid,
  output logic       err,
  output logic       select_A,
  output logic       output_sel,
  output logic       ldA,
  output logic       ldQ,
  output logic       shf,
  output logic       Q_sel,
  output logic       ldQ0,
  output logic       ld_Div
);

  typedef enum logic [3:0] {
    IDLE, LD_DIV, LD_A, LD_Q, SHIFT, CALC, MERGE, OUT_Q, OUT_R, ERR
  } state_t;

  localparam logic [CNT_W-1:0] ITER_C = CNT_W'(ITER);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             div_zero;

  assign cnt_inc = cnt + CNT_W'(1);

`ifdef DIV_CONTROLLER_DIV0_CHECK_EN
  assign div_zero = (inBus == 6'd0);
`else
  // Operand bus is not inspected in this build; fold it into a deliberately unused net.
  logic unused_bus;
  assign unused_bus = ^inBus;
  assign div_zero   = 1'b0;
`endif

  // State and iteration counter registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and Moore output decode; Q_sel in SHIFT also looks at the registered counter.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ready      = 1'b0;
    bus_take   = 1'b0;
    out_valid  = 1'b0;
    err        = 1'b0;
    select_A   = 1'b0;
    output_sel = 1'b0;
    ldA        = 1'b0;
    ldQ        = 1'b0;
    shf        = 1'b0;
    Q_sel      = 1'b0;
    ldQ0       = 1'b0;
    ld_Div     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = LD_DIV;
      end
      LD_DIV: begin
        ld_Div    = 1'b1;
        bus_take  = 1'b1;
        state_nxt = div_zero ? ERR : LD_A;
      end
      LD_A: begin
        ldA       = 1'b1;
        bus_take  = 1'b1;
        state_nxt = LD_Q;
      end
      LD_Q: begin
        ldQ       = 1'b1;
        bus_take  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        shf       = 1'b1;
        // First shift has no previous quotient bit to insert.
        Q_sel     = (cnt != '0);
        state_nxt = CALC;
      end
      CALC: begin
        ldA       = 1'b1;
        select_A  = 1'b1;
        ldQ0      = 1'b1;
        cnt_nxt   = cnt_inc;
        state_nxt = (cnt_inc < ITER_C) ? SHIFT : MERGE;
      end
      MERGE: begin
        shf       = 1'b1;
        Q_sel     = 1'b1;
        state_nxt = OUT_Q;
      end
      OUT_Q: begin
        output_sel = 1'b1;
        out_valid  = 1'b1;
        state_nxt  = OUT_R;
      end
      OUT_R: begin
        out_valid = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_controller.sv
// Randomised bench for div_controller against a cycle-offset reference model.
// Latency: one check per clock, sampled on the falling edge.
// Backpressure: n/a (controller has no stall input).
module tb_div_controller;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [5:0] inBus;
  logic       ready, bus_take, out_valid, err, select_A, output_sel;
  logic       ldA, ldQ, shf, Q_sel, ldQ0, ld_Div;

  div_controller dut (
    .clk(clk), .rst(rst), .start(start), .inBus(inBus),
    .ready(ready), .bus_take(bus_take), .out_valid(out_valid), .err(err),
    .select_A(select_A), .output_sel(output_sel), .ldA(ldA), .ldQ(ldQ),
    .shf(shf), .Q_sel(Q_sel), .ldQ0(ldQ0), .ld_Div(ld_Div)
  );

  always #5 clk = ~clk;

`ifdef DIV_CONTROLLER_DIV0_CHECK_EN
  localparam bit DIV0 = 1'b1;
`else
  localparam bit DIV0 = 1'b0;
`endif
  localparam int OFF_ERR = 99;

  int n_vec = 0;
  int n_err = 0;
  // Model: cycles elapsed since start was accepted (0 = idle, OFF_ERR = abort cycle).
  int off = 0;
  int ov_cnt, ldd_cnt, err_cnt;

  logic [11:0] obs;
  assign obs = {ready, bus_take, out_valid, err, select_A, output_sel,
                ldA, ldQ, shf, Q_sel, ldQ0, ld_Div};

  // Expected outputs purely from the position in the division timeline.
  function automatic logic [11:0] exp_vec(input int o);
    logic r, bt, ov, e, sa, os, la, lq, sh, qs, lq0, ld;
    {r, bt, ov, e, sa, os, la, lq, sh, qs, lq0, ld} = '0;
    if (o == 0) r = 1'b1;
    else if (o == 1) begin bt = 1'b1; ld = 1'b1; end
    else if (o == 2) begin bt = 1'b1; la = 1'b1; end
    else if (o == 3) begin bt = 1'b1; lq = 1'b1; end
    else if (o >= 4 && o <= 15) begin
      if (o % 2 == 0) begin sh = 1'b1; qs = (o != 4); end
      else begin la = 1'b1; sa = 1'b1; lq0 = 1'b1; end
    end
    else if (o == 16) begin sh = 1'b1; qs = 1'b1; end
    else if (o == 17) begin os = 1'b1; ov = 1'b1; end
    else if (o == 18) ov = 1'b1;
    else if (o == OFF_ERR) e = 1'b1;
    return {r, bt, ov, e, sa, os, la, lq, sh, qs, lq0, ld};
  endfunction

  function automatic logic [5:0] bus_for(input int o, input bit zero_div);
    logic [5:0] v;
    v = 6'($urandom_range(1, 63));
    if (o == 1) v = zero_div ? 6'd0 : 6'd5;
    else if (o == 2) v = 6'd0;
    else if (o == 3) v = 6'd27;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h (model offset %0d)", tag, $time, got, exp, off);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, then compare on the falling edge.
  task automatic tick(input logic s, input logic r, input logic [5:0] b);
    start = s;
    rst   = r;
    inBus = b;
    @(posedge clk);
    if (r) off = 0;
    else if (off == 0) off = s ? 1 : 0;
    else if (off == OFF_ERR || off == 18) off = 0;
    else if (off == 1 && b == 6'd0 && DIV0) off = OFF_ERR;
    else off = off + 1;
    @(negedge clk);
    check("outs", 32'(obs), 32'(exp_vec(off)));
    check("excl", 32'((32'(ldA) + 32'(ldQ) + 32'(ld_Div) <= 1) && !(shf && ldA)), 32'd1);
    ov_cnt  += 32'(out_valid);
    ldd_cnt += 32'(ld_Div);
    err_cnt += 32'(err);
  endtask

  task automatic drain();
    int guard = 0;
    while (off != 0 && guard < 40) begin
      tick(1'b0, 1'b0, bus_for(off, 1'b0));
      guard++;
    end
    check("drain", 32'(off), 32'd0);
  endtask

  initial begin
    start = 1'b0; rst = 1'b0; inBus = 6'd0;
    ov_cnt = 0; ldd_cnt = 0; err_cnt = 0;

    // Reset then idle.
    tick(1'b0, 1'b1, 6'd0);
    repeat (5) tick(1'b0, 1'b0, 6'($urandom));

    // Nominal division with operands 5 / {0,27}.
    ov_cnt = 0;
    tick(1'b1, 1'b0, 6'd0);
    repeat (19) tick(1'b0, 1'b0, bus_for(off, 1'b0));
    check("nominal_ov", 32'(ov_cnt), 32'd2);

    // start held high: one division per window, no queued request.
    ldd_cnt = 0;
    repeat (30) tick(1'b1, 1'b0, bus_for(off, 1'b0));
    check("held_start_runs", 32'(ldd_cnt), 32'd2);
    drain();

    // Reset during iterations abandons the division.
    ov_cnt = 0; err_cnt = 0;
    tick(1'b1, 1'b0, 6'd0);
    repeat (8) tick(1'b0, 1'b0, bus_for(off, 1'b0));
    tick(1'b0, 1'b1, bus_for(off, 1'b0));
    repeat (3) tick(1'b0, 1'b0, 6'd1);
    check("midrst_ov", 32'(ov_cnt), 32'd0);
    check("midrst_err", 32'(err_cnt), 32'd0);
    tick(1'b1, 1'b0, 6'd0);
    repeat (19) tick(1'b0, 1'b0, bus_for(off, 1'b0));
    check("post_rst_ov", 32'(ov_cnt), 32'd2);

    // Zero divisor.
    ov_cnt = 0; err_cnt = 0;
    tick(1'b1, 1'b0, 6'd0);
    repeat (20) tick(1'b0, 1'b0, bus_for(off, 1'b1));
    check("div0_err", 32'(err_cnt), DIV0 ? 32'd1 : 32'd0);
    check("div0_ov", 32'(ov_cnt), DIV0 ? 32'd0 : 32'd2);
    drain();

    // Random start/rst/operand traffic.
    for (int i = 0; i < 10000; i++) begin
      logic       s, r;
      logic [5:0] b;
      s = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 49) == 0);
      b = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
      tick(s, r, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
